// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared widths, FSM states and tuple layout for the GEMM loop sequencer
package gemm_pkg;

  localparam int IW_DEF = 8;
  localparam int AW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [AW_DEF-1:0] a_addr;
    logic [AW_DEF-1:0] b_addr;
    logic [AW_DEF-1:0] c_addr;
    logic              acc_clr;
    logic              acc_out;
  } tuple_t;

endpackage

// File: rtl/loop_idx_cnt.sv
// rtl/loop_idx_cnt.sv - wrapping loop index counter with terminal flag and carry out
module loop_idx_cnt
  import gemm_pkg::*;
#(
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  input  logic [IW-1:0] fin,
  output logic [IW-1:0] value,
  output logic          at_fin,
  output logic          carry
);

  assign at_fin = (value == fin);
  assign carry  = step & at_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (step) begin
      value <= at_fin ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/gemm_loop_agen.sv
// rtl/gemm_loop_agen.sv - i/j/k loop sequencer emitting A/B/C addresses and accumulate flags
module gemm_loop_agen
  import gemm_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic [IW-1:0] m_fin,
  input  logic [IW-1:0] n_fin,
  input  logic [IW-1:0] k_fin,
  input  logic [AW-1:0] a_stride,
  input  logic [AW-1:0] b_stride,
  input  logic [AW-1:0] c_stride,
  output logic          busy,
  output logic          valid,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr,
  output logic          acc_clr,
  output logic          acc_out,
  output logic          done
);

  state_t        state, state_nx;
  logic [IW-1:0] m_q, n_q, k_q;
  logic [AW-1:0] as_q, bs_q, cs_q;
  logic [AW-1:0] a_base, c_base, b_koff;
  logic [IW-1:0] i_val, j_val, k_val;
  logic          i_at, j_at, k_at;
  logic          i_cy, j_cy, k_cy;
  logic          accept, issue, xfer;

  // busy stays high through the done cycle, so a start coinciding with done is dropped
  assign accept = (state == IDLE) & start & ~busy;
  assign issue  = (state == RUN) & (en | ~valid);
  assign xfer   = valid & en;

  loop_idx_cnt #(.IW(IW)) u_k (
    .clk(clk), .rst(rst), .clr(accept), .step(issue), .fin(k_q),
    .value(k_val), .at_fin(k_at), .carry(k_cy)
  );

  loop_idx_cnt #(.IW(IW)) u_j (
    .clk(clk), .rst(rst), .clr(accept), .step(k_cy), .fin(n_q),
    .value(j_val), .at_fin(j_at), .carry(j_cy)
  );

  // i only carries out on the final tuple of the pass
  loop_idx_cnt #(.IW(IW)) u_i (
    .clk(clk), .rst(rst), .clr(accept), .step(j_cy), .fin(m_q),
    .value(i_val), .at_fin(i_at), .carry(i_cy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (i_cy)   state_nx = DRAIN;
      DRAIN:   if (xfer)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      as_q    <= '0;
      bs_q    <= '0;
      cs_q    <= '0;
      a_base  <= '0;
      c_base  <= '0;
      b_koff  <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      done    <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_addr  <= '0;
      acc_clr <= 1'b0;
      acc_out <= 1'b0;
    end else begin
      done <= (state == DRAIN) & xfer;
      if (accept) begin
        m_q    <= m_fin;
        n_q    <= n_fin;
        k_q    <= k_fin;
        as_q   <= a_stride;
        bs_q   <= b_stride;
        cs_q   <= c_stride;
        a_base <= '0;
        c_base <= '0;
        b_koff <= '0;
        busy   <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (issue) begin
        valid   <= 1'b1;
        a_addr  <= a_base + AW'(k_val);
        b_addr  <= b_koff + AW'(j_val);
        c_addr  <= c_base + AW'(j_val);
        acc_clr <= (k_val == '0);
        acc_out <= k_at;
        b_koff  <= k_cy ? '0 : b_koff + bs_q;
        if (j_cy) begin
          a_base <= a_base + as_q;
          c_base <= c_base + cs_q;
        end
      end else if ((state == DRAIN) && xfer) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
